// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the datapath (master) and pipe_hazard_unit (slave).
// Carries the stall, redirect and operand inputs, plus the per-stage enable/flush outputs.
interface pipe_hazard_if #(
  parameter int NUM_STAGES    = 5,
  parameter int NUM_STALL_SRC = 3,
  parameter int REG_ADDR_W    = 5
);
  logic [NUM_STALL_SRC-1:0] stall_src;
  logic                     redirect;
  logic                     id_mem_read;
  logic [REG_ADDR_W-1:0]    id_rd_addr;
  logic [REG_ADDR_W-1:0]    rs1_addr;
  logic [REG_ADDR_W-1:0]    rs2_addr;
  logic [1:0]               rs_used;
  logic [NUM_STAGES-1:0]    stage_we;
  logic [NUM_STAGES-1:0]    stage_flush;
  logic                     redirect_pend;
  logic                     lu_active;

  modport master (
    output stall_src, redirect, id_mem_read, id_rd_addr, rs1_addr, rs2_addr, rs_used,
    input  stage_we, stage_flush, redirect_pend, lu_active
  );

  modport slave (
    input  stall_src, redirect, id_mem_read, id_rd_addr, rs1_addr, rs2_addr, rs_used,
    output stage_we, stage_flush, redirect_pend, lu_active
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard controller: stall > redirect > load-use bubble > normal flow.
// Optional HAZARD_PERF_CNT_EN adds stall / load-use / redirect performance counters.
module pipe_hazard_unit #(
  parameter int NUM_STAGES    = 5,
  parameter int NUM_STALL_SRC = 3,
  parameter int LU_STALL_CYC  = 1,
  parameter int FLUSH_DEPTH   = 2,
  parameter int REG_ADDR_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_lu_cyc,
  output logic [31:0] perf_redir,
`endif
  pipe_hazard_if.slave hif
);

  localparam int LU_CNT_W = $clog2(LU_STALL_CYC + 1);

  typedef enum logic {RUN, LU_WAIT} state_t;

  state_t                state_q, state_d;
  logic [LU_CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic                  pend_q, pend_d;

  logic                  stall;
  logic                  redir;
  logic                  lu_hit;
  logic                  lu_now;
  logic [NUM_STAGES-1:0] we_raw;
  logic [NUM_STAGES-1:0] flush_raw;

  assign stall  = |hif.stall_src;
  assign redir  = hif.redirect | pend_q;
  assign lu_hit = hif.id_mem_read && (hif.id_rd_addr != '0) &&
                  ((hif.rs_used[0] && (hif.rs1_addr == hif.id_rd_addr)) ||
                   (hif.rs_used[1] && (hif.rs2_addr == hif.id_rd_addr)));
  assign lu_now = (state_q == LU_WAIT) || ((state_q == RUN) && lu_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    pend_d    = 1'b0;
    we_raw    = '1;
    flush_raw = '0;
    if (stall) begin
      we_raw = '0;
      pend_d = pend_q | hif.redirect;
    end else if (redir) begin
      for (int i = 1; i <= FLUSH_DEPTH; i++) flush_raw[i] = 1'b1;
      state_d  = RUN;
      lu_cnt_d = '0;
    end else if (lu_now) begin
      we_raw[1:0]  = 2'b00;
      flush_raw[2] = 1'b1;
      if (state_q == RUN) begin
        if (LU_STALL_CYC > 1) begin
          state_d  = LU_WAIT;
          lu_cnt_d = LU_CNT_W'(LU_STALL_CYC - 1);
        end
      end else if (lu_cnt_q <= LU_CNT_W'(1)) begin
        // Last bubble of the sequence; clamp the counter so it never wraps.
        state_d  = RUN;
        lu_cnt_d = '0;
      end else begin
        lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
      end
    end
  end

  // Every output is forced low while reset is held, independent of the clock.
  assign hif.stage_we      = rst_n ? we_raw : '0;
  assign hif.stage_flush   = rst_n ? flush_raw : '0;
  assign hif.redirect_pend = rst_n & pend_q & stall;
  assign hif.lu_active     = rst_n & lu_now;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_lu_cyc    <= '0;
      perf_redir     <= '0;
    end else begin
      if (stall)                   perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (!stall && !redir && lu_now) perf_lu_cyc <= perf_lu_cyc + 32'd1;
      if (!stall && redir)         perf_redir     <= perf_redir + 32'd1;
    end
  end
`endif

endmodule
